z80_bus_master: RTL and testbench

Z80_BUS_MASTER -- requirements
Module: z80_bus_master

---
 rtl/tv80_bus_pkg.sv | 27 ++
 rtl/z80_bus_master.sv | 129 ++++++++++++
 tb/tb_z80_bus_master.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tv80_bus_pkg.sv
// Shared constants for the Z80-style bus master.
// Holds the FSM state encodings and the read-data value returned for writes.
// No ports.
package tv80_bus_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_BREQ = 3'd1;
    localparam logic [2:0] ST_T1   = 3'd2;
    localparam logic [2:0] ST_T2   = 3'd3;
    localparam logic [2:0] ST_TW   = 3'd4;
    localparam logic [2:0] ST_T3   = 3'd5;
    localparam logic [2:0] ST_RSP  = 3'd6;

    localparam logic [7:0] WR_RSP_DATA = 8'h00;

    // States in which the master owns and drives the bus.
    function automatic logic on_bus(input logic [2:0] st);
        return (st == ST_T1) || (st == ST_T2) || (st == ST_TW) ||
               (st == ST_T3) || (st == ST_RSP);
    endfunction

    // States in which a memory cycle is in progress (MREQ active).
    function automatic logic in_cycle(input logic [2:0] st);
        return (st == ST_T1) || (st == ST_T2) || (st == ST_TW) || (st == ST_T3);
    endfunction

endpackage

// File: rtl/z80_bus_master.sv
// Z80-style memory-cycle initiator.
// Requests the bus from the CPU with BUSRQ/BUSAK, then runs one read or
// write cycle (T1, T2, optional TW wait states, T3) per accepted request and
// returns the result on a valid/ready response channel. The bus is kept
// between back-to-back requests.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_*                  request channel (srdy/drdy handshake, addr, write, wdata)
//   rsp_*                  response channel (srdy/drdy handshake, rdata)
//   busrq_n, busak_n       bus request to / acknowledge from the CPU
//   bus_oe                 output enable for A, strobes and dout drivers
//   A, dout, di            address, write data, read data
//   mreq_n, rd_n, wr_n     memory strobes
//   wait_n                 wait request from the memory target
//
// state | meaning
// ------+-----------------------------------------------------
// IDLE  | no request, bus released
// BREQ  | busrq_n low, waiting for busak_n
// T1    | address out, mreq_n low, rd_n low for reads
// T2    | wr_n low for writes, wait_n sampled at end
// TW    | wait state, repeats while wait_n is low
// T3    | last strobe cycle, read data captured at exit
// RSP   | response valid, strobes idle, bus still held
module z80_bus_master
    import tv80_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_srdy,
    output logic        req_drdy,
    input  logic [15:0] req_addr,
    input  logic        req_write,
    input  logic [7:0]  req_wdata,
    output logic        rsp_srdy,
    input  logic        rsp_drdy,
    output logic [7:0]  rsp_rdata,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic        bus_oe,
    output logic [15:0] A,
    output logic [7:0]  dout,
    input  logic [7:0]  di,
    output logic        mreq_n,
    output logic        rd_n,
    output logic        wr_n,
    input  logic        wait_n
);

    logic [2:0]  state, state_nxt;
    logic [15:0] addr_q, addr_nxt;
    logic        write_q, write_nxt;
    logic [7:0]  wdata_q, wdata_nxt;
    logic        xfer;

    assign req_drdy = (state == ST_IDLE) || ((state == ST_RSP) && rsp_drdy);
    assign xfer     = req_srdy && req_drdy;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (xfer) state_nxt = ST_BREQ;
            ST_BREQ: if (!busak_n) state_nxt = ST_T1;
            ST_T1:   state_nxt = ST_T2;
            ST_T2,
            ST_TW:   state_nxt = wait_n ? ST_T3 : ST_TW;
            ST_T3:   state_nxt = ST_RSP;
            ST_RSP:  if (rsp_drdy) state_nxt = req_srdy ? ST_T1 : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_nxt  = addr_q;
        write_nxt = write_q;
        wdata_nxt = wdata_q;
        if (xfer) begin
            addr_nxt  = req_addr;
            write_nxt = req_write;
            wdata_nxt = req_wdata;
        end
    end

    // Bus outputs are decoded from the next state (and the request that will
    // be held in it) so every bus pin comes straight from a flop.
    logic        d_on_bus, d_in_cyc, d_wr_phase;

    always_comb begin
        d_on_bus   = on_bus(state_nxt);
        d_in_cyc   = in_cycle(state_nxt);
        d_wr_phase = (state_nxt == ST_T2) || (state_nxt == ST_TW) ||
                     (state_nxt == ST_T3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr_q    <= 16'h0000;
            write_q   <= 1'b0;
            wdata_q   <= 8'h00;
            busrq_n   <= 1'b1;
            bus_oe    <= 1'b0;
            A         <= 16'h0000;
            dout      <= 8'h00;
            mreq_n    <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            rsp_srdy  <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            state     <= state_nxt;
            addr_q    <= addr_nxt;
            write_q   <= write_nxt;
            wdata_q   <= wdata_nxt;
            busrq_n   <= (state_nxt == ST_IDLE);
            bus_oe    <= d_on_bus;
            A         <= d_on_bus ? addr_nxt : 16'h0000;
            dout      <= (d_on_bus && write_nxt) ? wdata_nxt : 8'h00;
            mreq_n    <= !d_in_cyc;
            rd_n      <= !(d_in_cyc && !write_nxt);
            wr_n      <= !(d_wr_phase && write_nxt);
            rsp_srdy  <= (state_nxt == ST_RSP);
            if (state == ST_T3)
                rsp_rdata <= write_q ? WR_RSP_DATA : di;
        end
    end

endmodule

// File: tb/tb_z80_bus_master.sv
// Directed bench for z80_bus_master with a small CPU/memory responder model.
module tb_z80_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_srdy;
    logic        req_drdy;
    logic [15:0] req_addr;
    logic        req_write;
    logic [7:0]  req_wdata;
    logic        rsp_srdy;
    logic        rsp_drdy;
    logic [7:0]  rsp_rdata;
    logic        busrq_n;
    logic        busak_n = 1'b1;
    logic        bus_oe;
    logic [15:0] A;
    logic [7:0]  dout;
    logic [7:0]  di;
    logic        mreq_n;
    logic        rd_n;
    logic        wr_n;
    logic        wait_n;

    int checks = 0;
    int errors = 0;

    z80_bus_master dut (
        .clk       (clk),
        .reset     (reset),
        .req_srdy  (req_srdy),
        .req_drdy  (req_drdy),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .rsp_srdy  (rsp_srdy),
        .rsp_drdy  (rsp_drdy),
        .rsp_rdata (rsp_rdata),
        .busrq_n   (busrq_n),
        .busak_n   (busak_n),
        .bus_oe    (bus_oe),
        .A         (A),
        .dout      (dout),
        .di        (di),
        .mreq_n    (mreq_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .wait_n    (wait_n)
    );

    always #5 clk = ~clk;

    // CPU grants the bus one clock after the request.
    always @(posedge clk) busak_n <= busrq_n;

    // Memory responder: fixed contents plus one writable location, and a
    // programmable number of wait_n=0 samples per cycle (from T2 onward).
    logic [15:0] wr_addr = 16'hFFFF;
    logic [7:0]  wr_data = 8'h00;
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    int          mcyc = 0;

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        if (a == wr_addr) return wr_data;
        case (a)
            16'h8010: return 8'hA5;
            16'h8030: return 8'h5A;
            16'h8040: return 8'h77;
            default:  return 8'hEE;
        endcase
    endfunction

    assign di     = rd_n ? 8'hFF : mem_rd(A);
    assign wait_n = (wait_cnt >= wait_cfg);

    always @(posedge clk) begin
        if (!mreq_n) begin
            mcyc <= mcyc + 1;
            if (mcyc >= 1 && wait_cnt < wait_cfg) wait_cnt <= wait_cnt + 1;
            if (!wr_n) begin
                wr_addr <= A;
                wr_data <= dout;
            end
        end else begin
            mcyc     <= 0;
            wait_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int m_cnt, r_cnt, w_cnt, breq_cnt;
    logic rdata_moved;

    // From the current negedge, count strobe-low cycles until rsp_srdy.
    task automatic wait_rsp();
        logic [7:0] start;
        start = rsp_rdata;
        m_cnt = 0; r_cnt = 0; w_cnt = 0; breq_cnt = 0; rdata_moved = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_srdy) break;
            if (!mreq_n) m_cnt++;
            if (!rd_n) r_cnt++;
            if (!wr_n) w_cnt++;
            if (!busrq_n && !bus_oe) breq_cnt++;
            if (rsp_rdata !== start) rdata_moved = 1'b1;
            @(negedge clk);
        end
        chk("rsp_arrives", rsp_srdy, 1);
    endtask

    task automatic issue(input logic [15:0] a, input logic w, input logic [7:0] d);
        req_srdy  = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
        @(posedge clk);
        #1 req_srdy = 1'b0;
        @(negedge clk);
        chk("busrq_after_xfer", busrq_n, 0);
    endtask

    task automatic accept_to_idle();
        rsp_drdy = 1'b1;
        @(posedge clk);
        #1 rsp_drdy = 1'b0;
        @(negedge clk);
        chk("idle_busrq_n", busrq_n, 1);
        chk("idle_bus_oe", bus_oe, 0);
        chk("idle_rsp_srdy", rsp_srdy, 0);
    endtask

    initial begin
        reset = 1'b1; req_srdy = 1'b0; req_addr = 16'h0; req_write = 1'b0;
        req_wdata = 8'h0; rsp_drdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busrq_n", busrq_n, 1);
        chk("rst_bus_oe", bus_oe, 0);
        chk("rst_strobes", {mreq_n, rd_n, wr_n}, 3'b111);
        chk("rst_A", A, 16'h0000);
        chk("rst_dout", dout, 8'h00);
        chk("rst_rsp", {rsp_srdy, rsp_rdata}, 9'h000);
        chk("rst_req_drdy", req_drdy, 1);

        // Plain read, no wait states.
        issue(16'h8010, 1'b0, 8'h00);
        chk("breq_bus_oe", bus_oe, 0);
        wait_rsp();
        chk("rd_mreq_len", m_cnt, 3);
        chk("rd_rd_len", r_cnt, 3);
        chk("rd_wr_len", w_cnt, 0);
        chk("rd_data", rsp_rdata, 8'hA5);
        chk("rsp_strobes", {mreq_n, rd_n, wr_n}, 3'b111);
        chk("rsp_bus_held", {bus_oe, busrq_n}, 2'b10);
        chk("rsp_req_drdy", req_drdy, 0);
        accept_to_idle();

        // Write, then back-to-back readback without a new bus request.
        issue(16'h8020, 1'b1, 8'h3C);
        wait_rsp();
        chk("wr_mreq_len", m_cnt, 3);
        chk("wr_wr_len", w_cnt, 2);
        chk("wr_rd_len", r_cnt, 0);
        chk("wr_rsp_data", rsp_rdata, 8'h00);
        chk("wr_mem_addr", wr_addr, 16'h8020);
        chk("wr_mem_data", wr_data, 8'h3C);
        chk("wr_rsp_dout", dout, 8'h3C);
        req_srdy = 1'b1; req_addr = 16'h8020; req_write = 1'b0; rsp_drdy = 1'b1;
        @(posedge clk);
        #1 req_srdy = 1'b0; rsp_drdy = 1'b0;
        @(negedge clk);
        chk("b2b_t1_strobes", {mreq_n, rd_n, wr_n}, 3'b001);
        chk("b2b_A", A, 16'h8020);
        chk("b2b_busrq_n", busrq_n, 0);
        chk("b2b_dout", dout, 8'h00);
        wait_rsp();
        chk("b2b_mreq_len", m_cnt, 3);
        chk("b2b_no_breq", breq_cnt, 0);
        chk("b2b_data", rsp_rdata, 8'h3C);
        accept_to_idle();

        // Read with four wait_n=0 samples.
        wait_cfg = 4;
        issue(16'h8030, 1'b0, 8'h00);
        wait_rsp();
        chk("wait_mreq_len", m_cnt, 7);
        chk("wait_rd_len", r_cnt, 7);
        chk("wait_no_early_cap", rdata_moved, 0);
        chk("wait_data", rsp_rdata, 8'h5A);
        wait_cfg = 0;

        // Response backpressure for five clocks.
        req_srdy = 1'b1; req_addr = 16'h8010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp", {rsp_srdy, rsp_rdata}, 9'h15A);
            chk("hold_req_drdy", req_drdy, 0);
            chk("hold_strobes", {mreq_n, rd_n, wr_n}, 3'b111);
        end
        req_srdy = 1'b0;
        accept_to_idle();

        // Reset while in a wait state.
        wait_cfg = 10;
        issue(16'h8040, 1'b0, 8'h00);
        m_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!mreq_n) m_cnt++;
            if (m_cnt == 4) break;
            @(negedge clk);
        end
        chk("tw_reached", {m_cnt[3:0], mreq_n, rd_n}, 6'b010000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rtw_strobes", {mreq_n, rd_n, wr_n}, 3'b111);
        chk("rtw_bus", {busrq_n, bus_oe}, 2'b10);
        chk("rtw_rsp", {rsp_srdy, rsp_rdata}, 9'h000);
        reset = 1'b0;
        wait_cfg = 0;
        rdata_moved = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_srdy || !mreq_n) rdata_moved = 1'b1;
        end
        chk("rtw_no_rsp", rdata_moved, 0);
        chk("rtw_idle", {req_drdy, busrq_n, bus_oe}, 3'b110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
